// File: rtl/riscv_bus_pkg.sv
// Shared bus definitions for the CPU-side memory arbiter.
//   arb_state_e     : arbiter FSM state encoding
//   grant_e         : which requester owns the bus (fetch or data)
//   TIMEOUT_DEFAULT : default watchdog limit in BUSY cycles
package riscv_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } grant_e;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory bus between the CPU
// instruction-fetch port and its load/store port, with a bus watchdog.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   if_req/if_addr                   fetch request (held until if_ack)
//   if_rdata/if_ack                  fetch result, one-cycle acknowledge
//   d_req/d_we/d_addr/d_be/d_wdata   load/store request (held until d_ack)
//   d_rdata/d_ack                    load result, one-cycle acknowledge
//   err                              with an ack: the access timed out
//   stall                            a request is pending and not yet acked
//   bus_req/bus_we/bus_addr/bus_be/bus_wdata  registered granted request
//   bus_ack/bus_rdata                memory completion and read data
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | sample requests, pick a winner, latch its request
// BUSY    | bus transaction active, wait for bus_ack or watchdog expiry
// RESP    | one-cycle acknowledge to the granted requester
module mem_arbiter
  import riscv_bus_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [XLEN-1:0]   if_addr,
  output logic [XLEN-1:0]   if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [XLEN/8-1:0] d_be,
  input  logic [XLEN-1:0]   d_wdata,
  output logic [XLEN-1:0]   d_rdata,
  output logic              d_ack,
  output logic              err,
  output logic              stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN/8-1:0] bus_be,
  output logic [XLEN-1:0]   bus_wdata,
  input  logic              bus_ack,
  input  logic [XLEN-1:0]   bus_rdata
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  arb_state_e        state_q, state_d;
  grant_e            grant_q, grant_d;
  grant_e            last_q;
  logic [TW-1:0]     timer_q;
  logic [XLEN-1:0]   rdata_q;
  logic              err_q;
  logic              start, done, expire;
  logic              resp_act;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    start   = 1'b0;
    done    = 1'b0;
    expire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (if_req || d_req) begin
          start   = 1'b1;
          state_d = ST_BUSY;
          if (if_req && d_req)
            grant_d = (last_q == GNT_IF) ? GNT_D : GNT_IF;
          else if (d_req)
            grant_d = GNT_D;
          else
            grant_d = GNT_IF;
        end
      end
      ST_BUSY: begin
        // A bus_ack on the expiry cycle wins over the watchdog.
        if (bus_ack) begin
          done    = 1'b1;
          state_d = ST_RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          expire  = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= GNT_IF;
      last_q    <= GNT_IF;
      timer_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      if (start) begin
        timer_q <= '0;
        if (grant_d == GNT_D) begin
          bus_we    <= d_we;
          bus_addr  <= d_addr;
          bus_be    <= d_be;
          bus_wdata <= d_wdata;
        end else begin
          bus_we    <= 1'b0;
          bus_addr  <= if_addr;
          bus_be    <= '1;
          bus_wdata <= '0;
        end
      end else if (state_q == ST_BUSY) begin
        timer_q <= timer_q + TW'(1);
      end
      if (done) begin
        rdata_q <= bus_we ? '0 : bus_rdata;
        err_q   <= 1'b0;
        last_q  <= grant_q;
      end else if (expire) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
        last_q  <= grant_q;
      end
    end
  end

  // Reset during RESP suppresses the acknowledge in that same cycle.
  assign resp_act = (state_q == ST_RESP) && !rst;
  assign if_ack   = resp_act && (grant_q == GNT_IF);
  assign d_ack    = resp_act && (grant_q == GNT_D);
  assign err      = resp_act && err_q;
  assign if_rdata = rdata_q;
  assign d_rdata  = rdata_q;
  assign bus_req  = (state_q == ST_BUSY);
  assign stall    = (if_req & ~if_ack) | (d_req & ~d_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected bus transactions and acks are
// queued when requests are driven, and popped by the bus responder and the
// ack monitor as the design produces them.
module tb_mem_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  logic [31:0] if_rdata, d_rdata;
  logic        if_ack, d_ack, err, stall;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  mem_arbiter #(.XLEN(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
    .err(err), .stall(stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
    bit          err;
    int          cyc;
  } ack_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  ack_t exp_q[$];
  txn_t bus_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  int resp_lat   = 1;  // 0: never answer
  int resp_extra = 0;  // extra bus_ack cycles after the real one
  bit force_ack  = 1'b0;
  int busy_cnt   = 0;
  int extra_left = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0000_0013 : ((a ^ 32'h5A5A_0000) + 32'h11);
  endfunction

  task automatic push_txn(input bit we, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd);
    txn_t t;
    t.we = we; t.addr = a; t.be = be; t.wdata = wd;
    bus_q.push_back(t);
  endtask

  task automatic expect_acc(input bit is_d, input bit we, input logic [31:0] a,
                            input logic [3:0] be, input logic [31:0] wd,
                            input int ack_cyc, input bit timed_out);
    ack_t e;
    push_txn(we, a, is_d ? be : 4'hF, wd);
    e.is_d  = is_d;
    e.err   = timed_out;
    e.rdata = (timed_out || we) ? 32'h0 : mem_val(a);
    e.cyc   = ack_cyc;
    exp_q.push_back(e);
  endtask

  // Bus responder: answers after resp_lat BUSY cycles, checks the request.
  always @(negedge clk) begin
    #1;
    if (bus_req) begin
      busy_cnt++;
      if (busy_cnt == 1) begin
        if (bus_q.size() == 0) chk("bus_unexpected", 1, 0);
        else begin
          txn_t t;
          t = bus_q.pop_front();
          chk("bus_we", bus_we, t.we);
          chk("bus_addr", bus_addr, t.addr);
          chk("bus_be", bus_be, t.be);
          if (t.we) chk("bus_wdata", bus_wdata, t.wdata);
        end
      end
    end else begin
      busy_cnt = 0;
    end
    if (bus_req && resp_lat != 0 && busy_cnt == resp_lat) begin
      bus_ack    = 1'b1;
      bus_rdata  = mem_val(bus_addr);
      extra_left = resp_extra;
    end else if (extra_left > 0) begin
      bus_ack   = 1'b1;
      bus_rdata = 32'hBAD0_BAD0;
      extra_left--;
    end else if (force_ack) begin
      bus_ack   = 1'b1;
      bus_rdata = 32'hBAD0_BAD0;
    end else begin
      bus_ack   = 1'b0;
      bus_rdata = 32'h0;
    end
  end

  // Ack monitor.
  always @(negedge clk) begin
    #2;
    if (if_ack || d_ack) begin
      chk("one_ack", if_ack & d_ack, 0);
      if (exp_q.size() == 0) chk("spurious_ack", 1, 0);
      else begin
        ack_t e;
        e = exp_q.pop_front();
        chk("ack_port", d_ack, e.is_d);
        chk("ack_cycle", cyc, e.cyc);
        chk("ack_rdata", d_ack ? d_rdata : if_rdata, e.rdata);
        chk("ack_err", err, e.err);
      end
    end else if (!rst) begin
      chk("err_no_ack", err, 0);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_single(input bit is_d, input bit we, input logic [31:0] a,
                            input logic [3:0] be, input logic [31:0] wd, input int lat);
    int ac;
    bit got;
    ac = cyc + ((lat == 0) ? TO + 1 : lat + 1);
    resp_lat = lat;
    expect_acc(is_d, is_d ? we : 1'b0, a, be, wd, ac, lat == 0);
    if (is_d) begin
      d_we = we; d_addr = a; d_be = be; d_wdata = wd; d_req = 1'b1;
    end else begin
      if_addr = a; if_req = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      chk("stall", stall, cyc != ac);
      if (is_d ? d_ack : if_ack) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    d_req = 1'b0;
    if_req = 1'b0;
    chk("ack_wait", got, 1);
    @(negedge clk);
  endtask

  // Both requesters held; n accesses each, data wins the first tie.
  task automatic run_both(input int n, input bit dwe);
    int c, di, ii;
    c = cyc;
    resp_lat = 1;
    di = 0;
    ii = 0;
    for (int k = 0; k < 2 * n; k++) begin
      if (k % 2 == 0)
        expect_acc(1'b1, dwe, 32'h2000 + 4 * (k / 2), 4'hF, 32'hDEADBEEF + k / 2,
                   c + 2 + 3 * k, 1'b0);
      else
        expect_acc(1'b0, 1'b0, 32'h400 + 4 * (k / 2), 4'hF, 32'h0, c + 2 + 3 * k, 1'b0);
    end
    d_we = dwe; d_addr = 32'h2000; d_be = 4'hF; d_wdata = 32'hDEADBEEF; d_req = 1'b1;
    if_addr = 32'h400; if_req = 1'b1;
    for (int i = 0; i < 80 && !(di == n && ii == n); i++) begin
      #1;
      if (d_ack && di < n) begin
        di++;
        if (di == n) d_req = 1'b0;
        else begin
          d_addr  = 32'h2000 + 4 * di;
          d_wdata = 32'hDEADBEEF + di;
        end
      end
      if (if_ack && ii < n) begin
        ii++;
        if (ii == n) if_req = 1'b0;
        else if_addr = 32'h400 + 4 * ii;
      end
      @(negedge clk);
    end
    chk("both_done", (di == n) && (ii == n), 1);
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_be = '0; d_wdata = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_bus_req", bus_req, 0);
    chk("rst_if_ack", if_ack, 0);
    chk("rst_d_ack", d_ack, 0);
    chk("rst_err", err, 0);
    chk("rst_stall", stall, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_we", bus_we, 0);
    chk("rst_rdata", if_rdata, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Lone fetch, bus answers one cycle after bus_req.
    run_single(1'b0, 1'b0, 32'h100, 4'hF, 32'h0, 2);

    // Tie from reset: store first, then fetch.
    do_reset();
    run_both(1, 1'b1);

    // Six back-to-back accesses with both held.
    run_both(3, 1'b0);

    // Watchdog expiry, then a normal access.
    run_single(1'b1, 1'b0, 32'h5000, 4'h3, 32'h0, 0);
    run_single(1'b0, 1'b0, 32'h108, 4'hF, 32'h0, 1);
    run_single(1'b1, 1'b1, 32'h5004, 4'h6, 32'h1234_5678, 1);

    // Reset in the second BUSY cycle, late bus_ack afterwards.
    resp_lat = 0;
    push_txn(1'b0, 32'h200, 4'hF, 32'h0);
    if_addr = 32'h200;
    if_req = 1'b1;
    @(negedge clk);
    #1 chk("busy_bus_req", bus_req, 1);
    @(negedge clk);
    rst = 1'b1;
    if_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    force_ack = 1'b1;
    #1 chk("post_rst_bus_req", bus_req, 0);
    chk("post_rst_if_ack", if_ack, 0);
    @(negedge clk);
    force_ack = 1'b0;
    #1 chk("late_ack_bus_req", bus_req, 0);
    @(negedge clk);
    run_single(1'b0, 1'b0, 32'h204, 4'hF, 32'h0, 3);

    // bus_ack while IDLE, then an extra pulse during RESP.
    force_ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1 chk("idle_ack_bus_req", bus_req, 0);
    end
    force_ack = 1'b0;
    @(negedge clk);
    resp_extra = 1;
    run_single(1'b1, 1'b0, 32'h6000, 4'hF, 32'h0, 1);
    resp_extra = 0;
    #1 chk("after_resp_bus_req", bus_req, 0);
    @(negedge clk);
    #1 chk("after_resp_bus_req2", bus_req, 0);

    repeat (4) @(negedge clk);
    chk("sb_ack_empty", exp_q.size(), 0);
    chk("sb_bus_empty", bus_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit reached");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one unified single-port memory bus between the CPU's instruction-fetch requester and its load/store requester. It also stalls the core while either request is outstanding. The arbiter sits between the CPU's fetch/data ports and the memory/peripheral bus. It serializes accesses with round-robin priority and returns each result through a registered one-cycle acknowledge. A watchdog terminates accesses the bus never answers.

## Interface
- XLEN, 32, data/address width
- TIMEOUT, 255, max cycles BUSY waits for bus_ack before forced error completion (≥1)
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- if_req  in  1  fetch request; held high until if_ack
- if_addr  in  XLEN  fetch address
- if_rdata  out  XLEN  fetch data, valid while if_ack
- if_ack  out  1  one-cycle fetch completion
- d_req  in  1  load/store request; held high until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  XLEN  data address
- d_be  in  XLEN/8  byte enables
- d_wdata  in  XLEN  store data
- d_rdata  out  XLEN  load data, valid while d_ack
- d_ack  out  1  one-cycle data completion
- err  out  1  high with if_ack/d_ack when the access timed out
- stall  out  1  (if_req & ~if_ack) | (d_req & ~d_ack), combinational
- bus_req  out  1  bus transaction active
- bus_we, bus_addr, bus_be, bus_wdata  out  1/XLEN/XLEN/8/XLEN  registered copy of the granted request
- bus_ack  in  1  memory completion, single cycle
- bus_rdata  in  XLEN  read data, valid with bus_ack

## Operation
- FSM states: IDLE, BUSY, RESP. Registers: grant (0 = fetch, 1 = data), last (previous grant), timer, captured rdata, err.
- IDLE with neither request: stay in IDLE.
- IDLE with one request pending: grant that requester, latch its address/be/wdata/we, go to BUSY.
- IDLE with both requests pending: grant = ~last (round-robin). After reset last = fetch, so data wins the first tie.
- Fetch grants force bus_we = 0 and bus_be = all ones. bus_wdata is don't-care on fetch.
- BUSY: bus_req = 1, and bus_* stay stable.
  - On bus_ack: capture bus_rdata (0 for stores), set err = 0, set last = grant, go to RESP.
  - If timer reaches TIMEOUT-1 without bus_ack: capture rdata = 0, set err = 1, set last = grant, go to RESP.
- RESP: assert exactly one of if_ack/d_ack (selected by grant). Present the captured rdata on that port's rdata; err is valid. No new grant is made this cycle; next state is IDLE.
- Requests are sampled only in IDLE. A requester whose req is still high during its ack cycle is not re-granted from that cycle.
- timer clears on entry to BUSY and increments each BUSY cycle. It is XLEN-independent, width $clog2(TIMEOUT+1).
- bus_ack outside BUSY is ignored.
- Dropping a request mid-access is illegal; the access still completes and acks.

## Timing
- Reset values: state IDLE, bus_req 0, if_ack 0, d_ack 0, err 0, last fetch, timer 0, bus_* and *_rdata 0.
- Request seen in IDLE at cycle N: bus_req is high at N+1. With bus_ack at cycle N+k (k ≥ 1), the ack is at N+k+1 and state is IDLE at N+k+2.
- Minimum: 3 cycles per access, one ack per 3 cycles back-to-back.
- Timeout: ack at cycle N+TIMEOUT+1 with err = 1.
- bus_ack in the same cycle the timer expires counts as a normal completion (err = 0).
- rst mid-BUSY: the next cycle is IDLE with bus_req 0. The abandoned access is never acked, and a late bus_ack is ignored.
- rst during RESP: the ack is suppressed.

## Structure
- Shared package riscv_bus_pkg holds:
  - state encoding (IDLE/BUSY/RESP)
  - grant encoding (GNT_IF = 0, GNT_D = 1)
  - the default TIMEOUT constant
- Single module, no sub-modules; round-robin pick and watchdog are inline.

## Test plan
- Lone fetch, if_addr = 0x100, bus_ack one cycle after bus_req with rdata 0x00000013 -> bus_req at cycle 1, if_ack at cycle 3 with if_rdata 0x13, err 0, stall high on cycles 0–2.
- Simultaneous if_req and d_req from reset (store 0xDEADBEEF to 0x2000, be 0xF) -> data granted first (bus_we 1), then fetch, each acked once, in that order.
- Both requests held continuously for 6 accesses -> grants alternate D, IF, D, IF, D, IF; no ack is ever a duplicate.
- TIMEOUT = 4, bus_ack never asserted -> d_ack with err 1 and d_rdata 0 exactly 5 cycles after the request; the next request proceeds normally.
- rst asserted in the 2nd BUSY cycle, then bus_ack the cycle after -> no ack, bus_req 0; a fresh fetch afterwards completes correctly.
- bus_ack pulsed while IDLE and while in RESP -> no spurious acks and no state change.
